// File: rtl/spi_master.sv
// Single-byte SPI mode-0 master: CS framing, eight MSB-first clock pulses, one-cycle done.
// Optional internal MOSI->MISO loopback enabled by defining SPI_MASTER_LOOPBACK_EN.
module spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic       loopback
`endif
);

    localparam int CW = 16;

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] limit;
    logic          tick;
    logic [2:0]    bit_cnt;
    logic          last;
    logic [6:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic          sample;

    always_comb begin
        limit = '0;
        case (state)
            SETUP:     limit = CW'(CS_SETUP - 1);
            HIGH, LOW: limit = CW'(CLK_DIV - 1);
            HOLD:      limit = CW'(CS_HOLD - 1);
            default:   limit = '0;
        endcase
    end

    assign tick = (cnt == limit);

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample = loopback ? spi_mosi : spi_miso;
`else
    assign sample = spi_miso;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   if (tick) state_next = HIGH;
            HIGH:    if (tick) state_next = last ? HOLD : LOW;
            LOW:     if (tick) state_next = HIGH;
            HOLD:    if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus controls follow the registered state directly, so they change exactly at the edges.
    always_comb begin
        spi_cs_n = (state == IDLE);
        busy     = (state != IDLE);
        spi_clk  = (state == HIGH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            last     <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            spi_mosi <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sh    <= tx_data[6:0];
                        spi_mosi <= tx_data[7];
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        last     <= 1'b0;
                    end
                end
                SETUP, LOW: begin
                    if (tick) begin
                        cnt   <= '0;
                        rx_sh <= {rx_sh[6:0], sample};
                        last  <= (bit_cnt == 3'd7);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (tick) begin
                        cnt <= '0;
                        // The eighth fall leaves MOSI and the bit counter untouched.
                        if (!last) begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            spi_mosi <= tx_sh[6];
                            tx_sh    <= {tx_sh[5:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cnt      <= '0;
                        done     <= 1'b1;
                        rx_data  <= rx_sh;
                        spi_mosi <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two parameterisations checked every cycle against a timing-table model,
// plus directed bus-level checks with a mode-0 slave model.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] tx_data;
    logic       spi_miso;
    logic       loopback;
    logic [1:0] busy, done, sclk, mosi, cs_n;
    logic [7:0] rx [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .busy(busy[0]), .done(done[0]), .rx_data(rx[0]), .spi_clk(sclk[0]),
        .spi_mosi(mosi[0]), .spi_miso(spi_miso), .spi_cs_n(cs_n[0])
`ifdef SPI_MASTER_LOOPBACK_EN
        , .loopback(loopback)
`endif
    );

    spi_master #(.CLK_DIV(3), .CS_SETUP(1), .CS_HOLD(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .busy(busy[1]), .done(done[1]), .rx_data(rx[1]), .spi_clk(sclk[1]),
        .spi_mosi(mosi[1]), .spi_miso(spi_miso), .spi_cs_n(cs_n[1])
`ifdef SPI_MASTER_LOOPBACK_EN
        , .loopback(loopback)
`endif
    );

    function automatic int cd(input int n);  return (n == 0) ? 4 : 3; endfunction
    function automatic int csu(input int n); return (n == 0) ? 2 : 1; endfunction
    function automatic int chd(input int n); return (n == 0) ? 2 : 4; endfunction
    function automatic int tend(input int n); return csu(n) + 15 * cd(n) + chd(n); endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Slave model / random MISO source
    logic       slave_mode = 1'b1;
    logic [7:0] reply = 8'h00;
    logic       rand_miso = 1'b0;
    int         slave_idx = 0;
    logic       slave_bit;
    assign slave_bit = (slave_idx < 8) ? reply[7 - slave_idx] : 1'b0;
    assign spi_miso  = slave_mode ? slave_bit : rand_miso;

    // Behavioural model: position k (edges since acceptance) fully determines the bus.
    bit         m_active [2];
    bit         m_done   [2];
    int         m_k      [2];
    logic [7:0] m_byte   [2];
    logic [7:0] m_acc    [2];
    logic [7:0] m_rx     [2];

    initial begin
        for (int n = 0; n < 2; n++) begin
            m_active[n] = 0; m_done[n] = 0; m_k[n] = 0;
            m_byte[n] = 0; m_acc[n] = 0; m_rx[n] = 0;
        end
    end

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (!rst_n) begin
                m_active[n] = 0; m_done[n] = 0; m_rx[n] = 8'h00;
            end else if (!m_active[n]) begin
                m_done[n] = 0;
                if (start) begin
                    m_active[n] = 1; m_k[n] = 0; m_byte[n] = tx_data; m_acc[n] = 0;
                end
            end else begin
                int d;
                logic s;
                m_k[n]++;
                d = m_k[n] - csu(n);
                if (d >= 0 && d % (2 * cd(n)) == 0 && d / (2 * cd(n)) < 8) begin
                    s = spi_miso;
`ifdef SPI_MASTER_LOOPBACK_EN
                    if (loopback) s = m_byte[n][7 - d / (2 * cd(n))];
`endif
                    m_acc[n] = {m_acc[n][6:0], s};
                end
                if (m_k[n] == tend(n)) begin
                    m_active[n] = 0; m_done[n] = 1; m_rx[n] = m_acc[n];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int n = 0; n < 2; n++) begin
                int e_cs, e_busy, e_clk, e_mosi, e_done, d, idx;
                if (m_active[n]) begin
                    d = m_k[n] - csu(n);
                    e_cs = 0; e_busy = 1; e_done = 0;
                    e_clk = (d >= 0 && d < 16 * cd(n) && ((d / cd(n)) % 2 == 0)) ? 1 : 0;
                    idx = (d < 0) ? 0 : (d + cd(n)) / (2 * cd(n));
                    if (idx > 7) idx = 7;
                    e_mosi = int'(m_byte[n][7 - idx]);
                end else begin
                    e_cs = 1; e_busy = 0; e_clk = 0; e_mosi = 0; e_done = int'(m_done[n]);
                end
                chk($sformatf("cs_n[%0d]", n), int'(cs_n[n]), e_cs);
                chk($sformatf("busy[%0d]", n), int'(busy[n]), e_busy);
                chk($sformatf("spi_clk[%0d]", n), int'(sclk[n]), e_clk);
                chk($sformatf("mosi[%0d]", n), int'(mosi[n]), e_mosi);
                chk($sformatf("done[%0d]", n), int'(done[n]), e_done);
                chk($sformatf("rx_data[%0d]", n), int'(rx[n]), int'(m_rx[n]));
            end
        end
    end

    // Bus monitor on dut0 and slave shifter
    int         cs_low_cnt, rise_cnt, done_cnt, cs_fall_cyc;
    int         rise_cyc [8];
    logic [7:0] mosi_sh;
    logic       prev_clk = 1'b0, prev_cs = 1'b1;

    always @(negedge clk) begin
        if (cs_n[0] === 1'b0) cs_low_cnt++;
        if (prev_cs === 1'b1 && cs_n[0] === 1'b0) cs_fall_cyc = cyc;
        if (prev_clk === 1'b0 && sclk[0] === 1'b1) begin
            if (rise_cnt < 8) rise_cyc[rise_cnt] = cyc;
            rise_cnt++;
            mosi_sh = {mosi_sh[6:0], mosi[0]};
        end
        if (done[0] === 1'b1) done_cnt++;
        if (cs_n[0] !== 1'b0) slave_idx = 0;
        else if (prev_clk === 1'b1 && sclk[0] === 1'b0) slave_idx++;
        prev_clk = sclk[0];
        prev_cs  = cs_n[0];
    end

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        cs_low_cnt = 0; rise_cnt = 0; done_cnt = 0; cs_fall_cyc = 0; mosi_sh = 0;
        for (int i = 0; i < 8; i++) rise_cyc[i] = 0;
    endtask

    task automatic xfer(input logic [7:0] b);
        clear_mon();
        tx_data = b;
        start   = 1'b1;
        cycle(1);
        start   = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_done(input string nm);
        int i;
        for (i = 0; i < 300; i++) begin
            cycle(1);
            if (done_cnt != 0) break;
        end
        if (i == 300) chk({nm, "_timeout"}, 1, 0);
        cycle(3);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; tx_data = 8'h00; loopback = 1'b0;
        clear_mon();
        cycle(5);
        chk("reset_cs_n", int'(cs_n[0]), 1);
        chk("reset_clk", int'(sclk[0]), 0);
        chk("reset_mosi", int'(mosi[0]), 0);
        chk("reset_busy", int'(busy[0]), 0);
        chk("reset_done", int'(done[0]), 0);
        chk("reset_rx", int'(rx[0]), 8'h00);
        rst_n = 1'b1;
        cycle(2);

        reply = 8'h5A;
        xfer(8'hAA);
        wait_done("aa");
        chk("aa_rx", int'(rx[0]), 8'h5A);
        chk("aa_done_cnt", done_cnt, 1);
        chk("aa_cs_low", cs_low_cnt, 64);
        chk("aa_mosi", int'(mosi_sh), 8'hAA);

        reply = 8'h00;
        xfer(8'h96);
        wait_done("e96");
        chk("e96_rises", rise_cnt, 8);
        chk("e96_first_rise", rise_cyc[0] - cs_fall_cyc, 2);
        bad = 0;
        for (int i = 1; i < 8; i++) if (rise_cyc[i] - rise_cyc[i-1] != 8) bad++;
        chk("e96_rise_gap", bad, 0);
        chk("e96_mosi", int'(mosi_sh), 8'h96);

        xfer(8'h11);
        cycle(20);
        tx_data = 8'h22; start = 1'b1;
        cycle(1);
        start = 1'b0;
        wait_done("ign");
        cycle(100);
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_rises", rise_cnt, 8);
        chk("ign_mosi", int'(mosi_sh), 8'h11);

        xfer(8'h3C);
        begin
            int i;
            for (i = 0; i < 200; i++) begin
                cycle(1);
                if (rise_cnt >= 3) break;
            end
            if (i == 200) chk("rst3_timeout", 1, 0);
        end
        rst_n = 1'b0;
        cycle(1);
        chk("rstmid_cs_n", int'(cs_n[0]), 1);
        chk("rstmid_busy", int'(busy[0]), 0);
        chk("rstmid_clk", int'(sclk[0]), 0);
        chk("rstmid_mosi", int'(mosi[0]), 0);
        rst_n = 1'b1;
        cycle(80);
        chk("rstmid_no_done", done_cnt, 0);
        reply = 8'hC3;
        xfer(8'h3C);
        wait_done("c3");
        chk("c3_rx", int'(rx[0]), 8'hC3);

`ifdef SPI_MASTER_LOOPBACK_EN
        slave_mode = 1'b0; rand_miso = 1'b0;
        loopback = 1'b1;
        xfer(8'hC3);
        wait_done("lb1");
        chk("lb1_rx", int'(rx[0]), 8'hC3);
        loopback = 1'b0;
        xfer(8'hC3);
        wait_done("lb0");
        chk("lb0_rx", int'(rx[0]), 8'h00);
`endif

        slave_mode = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(7) == 0);
            tx_data   = 8'($urandom);
            rand_miso = 1'($urandom);
            rst_n     = ($urandom_range(399) != 0);
`ifdef SPI_MASTER_LOOPBACK_EN
            loopback  = 1'($urandom);
`endif
            cycle(1);
        end
        start = 1'b0; rst_n = 1'b1;
        cycle(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
